// File: rtl/im_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: FSM states,
// default geometry, and the word-index to byte-address mapping.
package im_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_LOAD,
        ST_WRITE,
        ST_CHK,
        ST_DONE,
        ST_ERR
    } ld_state_e;

    localparam int unsigned IM_DEPTH_DEF = 32;
    localparam logic [31:0] BASE_ADS_DEF = 32'h0000_0004;

    // Word k of the image lands at the PC value that fetches it.
    function automatic logic [31:0] word_ads(input logic [31:0] base, input logic [5:0] idx);
        return base + {24'd0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/im_loader_if.sv
// Byte-stream handshake plus instruction-memory write port, bundled so the
// loader sits between a stream source and the IM with a single port.
interface im_loader_if;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        im_wr_en;
    logic [31:0] im_wr_ads;
    logic [31:0] im_wr_data;

    modport slave (
        input  byte_in, byte_valid,
        output byte_ready, im_wr_en, im_wr_ads, im_wr_data
    );

    modport master (
        output byte_in, byte_valid,
        input  byte_ready, im_wr_en, im_wr_ads, im_wr_data
    );
endinterface

// File: rtl/im_word_assembler.sv
// Collects four bytes, LSB first, into a 32-bit word; word_full pulses for
// the single cycle after the fourth byte lands.
module im_word_assembler (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        shift_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        last_lane,
    output logic        word_full
);

    logic [1:0] idx_reg;
    logic       full_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_reg  <= 2'd0;
            full_reg <= 1'b0;
        end else if (clear) begin
            idx_reg  <= 2'd0;
            full_reg <= 1'b0;
        end else begin
            // Index wraps to 0 naturally after the fourth byte.
            if (shift_en)
                idx_reg <= idx_reg + 2'd1;
            full_reg <= shift_en && (idx_reg == 2'd3);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    lane_reg <= 8'd0;
                else if (clear)
                    lane_reg <= 8'd0;
                else if (shift_en && (idx_reg == 2'(gi)))
                    lane_reg <= byte_in;
            end
            assign word[8*gi +: 8] = lane_reg;
        end
    endgenerate

    assign last_lane = (idx_reg == 2'd3);
    assign word_full = full_reg;

endmodule

// File: rtl/im_loader.sv
// Boot-time instruction-memory writer: length header, LE word assembly,
// XOR checksum, and CPU hold until a verified image is in place.
module im_loader
    import im_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADS = BASE_ADS_DEF,
    parameter int unsigned IM_DEPTH = IM_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    im_loader_if.slave        bus,
    output logic [5:0]        word_cnt,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              cpu_hold
);

    ld_state_e   state_reg, state_next;
    logic [5:0]  n_reg;
    logic [5:0]  word_cnt_reg;
    logic [7:0]  chk_reg;
    logic [31:0] ads_reg;

    logic        accept;
    logic        len_bad;
    logic        enter_len;
    logic        load_byte;
    logic        last_lane;
    logic        word_full;
    logic [31:0] word;

    // Ready comes from the state register alone, never from byte_valid.
    assign bus.byte_ready = (state_reg == ST_LEN) || (state_reg == ST_LOAD) || (state_reg == ST_CHK);
    assign accept         = bus.byte_valid && bus.byte_ready;
    assign len_bad        = (bus.byte_in == 8'd0) || (32'(bus.byte_in) > IM_DEPTH);

    always_comb begin
        state_next = state_reg;
        enter_len  = 1'b0;
        load_byte  = 1'b0;
        case (state_reg)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_next = ST_LEN;
                    enter_len  = 1'b1;
                end
            end
            ST_LEN: begin
                if (accept)
                    state_next = len_bad ? ST_ERR : ST_LOAD;
            end
            ST_LOAD: begin
                if (accept) begin
                    load_byte = 1'b1;
                    if (last_lane)
                        state_next = ST_WRITE;
                end
            end
            ST_WRITE: begin
                state_next = (word_cnt_reg + 6'd1 == n_reg) ? ST_CHK : ST_LOAD;
            end
            ST_CHK: begin
                if (accept)
                    state_next = (bus.byte_in == chk_reg) ? ST_DONE : ST_ERR;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_reg <= ST_IDLE;
        else
            state_reg <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_reg        <= 6'd0;
            word_cnt_reg <= 6'd0;
            chk_reg      <= 8'd0;
            ads_reg      <= 32'd0;
        end else begin
            if (enter_len) begin
                word_cnt_reg <= 6'd0;
                chk_reg      <= 8'd0;
            end
            if ((state_reg == ST_LEN) && accept && !len_bad)
                n_reg <= bus.byte_in[5:0];
            if (load_byte)
                chk_reg <= chk_reg ^ bus.byte_in;
            // Address is captured with the completing byte so it is stable in WRITE.
            if (load_byte && last_lane)
                ads_reg <= word_ads(BASE_ADS, word_cnt_reg);
            if (state_reg == ST_WRITE)
                word_cnt_reg <= word_cnt_reg + 6'd1;
        end
    end

    im_word_assembler u_asm (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (enter_len),
        .shift_en  (load_byte),
        .byte_in   (bus.byte_in),
        .word      (word),
        .last_lane (last_lane),
        .word_full (word_full)
    );

    assign bus.im_wr_en   = word_full;
    assign bus.im_wr_ads  = ads_reg;
    assign bus.im_wr_data = word;

    assign word_cnt = word_cnt_reg;
    assign busy     = (state_reg == ST_LEN) || (state_reg == ST_LOAD) ||
                      (state_reg == ST_WRITE) || (state_reg == ST_CHK);
    assign done     = (state_reg == ST_DONE);
    assign err      = (state_reg == ST_ERR);
    assign cpu_hold = (state_reg != ST_DONE);

endmodule
